ddr2_wr_burst: RTL and testbench
================================

# ddr2_wr_burst

Write-side burst assembler sitting directly downstream of the 32→64 packer (`data_format_in`), consuming its 64-bit `dout`/`dout_vd` stream. Buffers packed words in a small FIFO and, once a full burst is available (or on flush), issues one write command followed by BURST_LEN data beats to the DDR2 controller's user port. The write address advances automatically per burst. Overflow is flagged sticky.

## Interface
- DATA_WIDTH, 64, width of data words in and out
- ADDR_WIDTH, 24, command address width, in word units
- BURST_LEN, 4, data beats per write command; power of 2, 2..8
- FIFO_DEPTH, 16, FIFO entries; power of 2, ≥ 2*BURST_LEN
- ADDR_BASE, 0, address of first burst after reset
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- din  in  DATA_WIDTH  packed write word (from packer dout)
- din_vd  in  1  din valid, one word per cycle
- flush  in  1  single-cycle pulse: write out residual words, zero-padded
- cmd_en  out  1  write command valid
- cmd_addr  out  ADDR_WIDTH  burst start address
- cmd_rdy  in  1  controller accepts command
- wr_data  out  DATA_WIDTH  write beat data
- wr_en  out  1  write beat valid
- wr_rdy  in  1  controller accepts beat
- fifo_count  out  log2(FIFO_DEPTH)+1  words currently stored
- ovf  out  1  sticky: a word was dropped because FIFO was full
- burst_done  out  1  one-cycle pulse after final beat of a burst accepted

## Operation
- Reset (reset=0, async): state IDLE; cmd_en=0, wr_en=0, wr_data=0, cmd_addr=ADDR_BASE, fifo_count=0, ovf=0, burst_done=0, flush_pend=0, FIFO pointers 0.
- FIFO push: din_vd=1 and count<FIFO_DEPTH → store din. din_vd=1 when full → word dropped, ovf←1 (held until reset). Push and pop in same cycle → count unchanged.
- FIFO is show-ahead: head word is combinationally available for wr_data.
- flush pulse sets flush_pend; flush while flush_pend already set has no extra effect.
- FSM (Moore for cmd_en/wr_en):
  - IDLE: if count≥BURST_LEN, or (flush_pend and count>0) → CMD; latch real_beats=min(count,BURST_LEN); clear flush_pend if count≤BURST_LEN. flush_pend with count=0 → clear flush_pend, stay IDLE.
  - CMD: cmd_en=1, cmd_addr stable. cmd_rdy=1 → DATA, beat counter←0.
  - DATA: wr_en=1. wr_data = FIFO head when beat<real_beats, else 0 (padding). On wr_rdy=1: beat+1; pop FIFO only if beat<real_beats. Last beat (beat=BURST_LEN-1) accepted → IDLE, cmd_addr←cmd_addr+BURST_LEN (mod 2^ADDR_WIDTH), burst_done=1 next cycle.
- wr_data = 0 whenever wr_en=0.
- Words pushed during CMD/DATA never enter the current padded burst; they wait for the next burst.
- cmd_addr always ends on a multiple of BURST_LEN offset from ADDR_BASE; padded bursts consume a full BURST_LEN address span.

## Timing
- Push at edge t → fifo_count reflects it at t+1.
- IDLE observes count≥BURST_LEN at t+1 → cmd_en=1 from t+2.
- cmd_rdy sampled with cmd_en=1 at edge c → wr_en=1 from c+1; zero-backpressure burst: BURST_LEN cycles of wr_en.
- Final beat accepted at edge d → wr_en=0 and burst_done=1 at d+1; earliest next cmd_en at d+2 (one IDLE cycle between bursts).
- cmd_en/cmd_addr and wr_en/wr_data held stable while cmd_rdy/wr_rdy low.
- Sustained throughput: BURST_LEN words per BURST_LEN+2 cycles; input at ≤1 word/2 cycles (packer rate) never overflows with ready controller.
- Reset asserted mid-burst: immediate return to reset values; buffered words discarded; partially sent burst not resumed.

## Test plan
- Push A0..A3 back-to-back, cmd_rdy=wr_rdy=1 → cmd_en at addr 0x000000, beats A0,A1,A2,A3, burst_done once; push A4..A7 → second cmd at addr 0x000004.
- Burst in DATA with wr_rdy pattern 1,0,0,1,0,1,1 → wr_data holds each value while wr_rdy=0; exactly 4 pops; order preserved.
- Push B0,B1 then flush pulse → cmd at next address, beats B0,B1,0,0; fifo_count returns 0; flush with empty FIFO → no command.
- cmd_rdy=0, push 17 words → fifo_count=16, ovf=1, 17th word absent; release cmd_rdy → four bursts of the first 16 words in order, ovf stays 1.
- ADDR_WIDTH=4, ADDR_BASE=12, two full bursts → cmd_addr 12 then 0 (wrap).
- Assert reset during beat 2 of a burst → cmd_en=wr_en=0, fifo_count=0, cmd_addr=ADDR_BASE same cycle; after release, fresh 4-word push produces normal burst at ADDR_BASE.

Source files
------------

// File: rtl/ddr2_wr_burst.sv
// Write-side burst assembler: buffers packed words in a show-ahead FIFO and issues
// one write command followed by BURST_LEN data beats (zero-padded on flush).
module ddr2_wr_burst #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_BASE  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          din_vd,
  input  logic                          flush,
  output logic                          cmd_en,
  output logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic                          cmd_rdy,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_en,
  input  logic                          wr_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf,
  output logic                          burst_done
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BEAT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, rd_ptr_inc;
  logic                  push, pop, full;
  logic                  flush_pend, flush_pend_nxt;
  logic [BEAT_W-1:0]     beat, beat_nxt, real_beats, real_beats_nxt;
  logic                  cmd_en_nxt, wr_en_nxt, burst_done_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt;
  logic [ADDR_WIDTH-1:0] cmd_addr_nxt;

  assign full       = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign push       = din_vd && !full;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

  // FIFO storage needs no reset: only slots below fifo_count are ever read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ovf        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (!push && pop) fifo_count <= fifo_count - CNT_W'(1);
      if (din_vd && full) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cmd_en     <= 1'b0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      cmd_addr   <= ADDR_WIDTH'(ADDR_BASE);
      burst_done <= 1'b0;
      flush_pend <= 1'b0;
      beat       <= '0;
      real_beats <= '0;
    end else begin
      state      <= state_nxt;
      cmd_en     <= cmd_en_nxt;
      wr_en      <= wr_en_nxt;
      wr_data    <= wr_data_nxt;
      cmd_addr   <= cmd_addr_nxt;
      burst_done <= burst_done_nxt;
      flush_pend <= flush_pend_nxt;
      beat       <= beat_nxt;
      real_beats <= real_beats_nxt;
    end
  end

  // Outputs are computed one cycle ahead so cmd_en/wr_en/wr_data leave flops
  always_comb begin
    state_nxt      = state;
    cmd_en_nxt     = 1'b0;
    wr_en_nxt      = 1'b0;
    wr_data_nxt    = '0;
    burst_done_nxt = 1'b0;
    cmd_addr_nxt   = cmd_addr;
    beat_nxt       = beat;
    real_beats_nxt = real_beats;
    pop            = 1'b0;
    flush_pend_nxt = flush_pend | flush;
    case (state)
      IDLE: begin
        if (fifo_count >= CNT_W'(BURST_LEN) || (flush_pend && fifo_count != '0)) begin
          state_nxt      = CMD;
          cmd_en_nxt     = 1'b1;
          real_beats_nxt = (fifo_count >= CNT_W'(BURST_LEN)) ? BEAT_W'(BURST_LEN)
                                                             : BEAT_W'(fifo_count);
          if (flush_pend && fifo_count <= CNT_W'(BURST_LEN)) flush_pend_nxt = 1'b0;
        end else if (flush_pend) begin
          flush_pend_nxt = 1'b0;
        end
      end
      CMD: begin
        cmd_en_nxt = 1'b1;
        if (cmd_rdy) begin
          state_nxt   = DATA;
          cmd_en_nxt  = 1'b0;
          wr_en_nxt   = 1'b1;
          beat_nxt    = '0;
          wr_data_nxt = (real_beats != '0) ? mem[rd_ptr] : '0;
        end
      end
      DATA: begin
        wr_en_nxt   = 1'b1;
        wr_data_nxt = wr_data;
        if (wr_rdy) begin
          pop = (beat < real_beats);
          if (beat == BEAT_W'(BURST_LEN - 1)) begin
            state_nxt      = IDLE;
            wr_en_nxt      = 1'b0;
            wr_data_nxt    = '0;
            burst_done_nxt = 1'b1;
            cmd_addr_nxt   = cmd_addr + ADDR_WIDTH'(BURST_LEN);
          end else begin
            beat_nxt = beat + BEAT_W'(1);
            // next real word sits one past the head being popped now
            wr_data_nxt = (beat_nxt < real_beats) ? mem[rd_ptr_inc] : '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ddr2_wr_burst.sv
// Bench for ddr2_wr_burst: queue-based reference model plus scenario tasks; a second
// instance with a 4-bit address and base 12 exercises address wrap.
module tb_ddr2_wr_burst;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] din = '0;
  logic        din_vd = 1'b0, flush = 1'b0, cmd_rdy = 1'b1, wr_rdy = 1'b1;
  logic        cmd_en, wr_en, ovf, burst_done;
  logic [23:0] cmd_addr;
  logic [63:0] wr_data;
  logic [4:0]  fifo_count;
  logic        cmd_en2, wr_en2, ovf2, burst_done2;
  logic [3:0]  cmd_addr2;
  logic [63:0] wr_data2;
  logic [4:0]  fifo_count2;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  ddr2_wr_burst dut (
    .clk(clk), .reset(rst_n), .din(din), .din_vd(din_vd), .flush(flush),
    .cmd_en(cmd_en), .cmd_addr(cmd_addr), .cmd_rdy(cmd_rdy), .wr_data(wr_data),
    .wr_en(wr_en), .wr_rdy(wr_rdy), .fifo_count(fifo_count), .ovf(ovf),
    .burst_done(burst_done));

  ddr2_wr_burst #(.ADDR_WIDTH(4), .ADDR_BASE(12)) dut2 (
    .clk(clk), .reset(rst_n), .din(din), .din_vd(din_vd), .flush(flush),
    .cmd_en(cmd_en2), .cmd_addr(cmd_addr2), .cmd_rdy(cmd_rdy), .wr_data(wr_data2),
    .wr_en(wr_en2), .wr_rdy(wr_rdy), .fifo_count(fifo_count2), .ovf(ovf2),
    .burst_done(burst_done2));

  // Reference model state (written only by the monitor)
  logic [63:0] q[$];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [23:0] cmd_obs[$];
  logic [3:0]  cmd2_obs[$];
  int          ncmd, nburst, done_cnt, viol, mbeat, real_n, sz_last, sz0;
  bit          m_ovf, done_exp, p_cmd, p_cmd_stall, p_wr_stall;
  logic [23:0] p_addr;
  logic [63:0] p_data, m_e;

  // Monitor: samples pre-edge values; a burst carries min(stored words, 4) real words
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete(); exp_q.delete(); obs_q.delete(); cmd_obs.delete(); cmd2_obs.delete();
        ncmd = 0; nburst = 0; done_cnt = 0; mbeat = 0; real_n = 0; sz_last = 0;
        m_ovf = 0; done_exp = 0; p_cmd = 0; p_cmd_stall = 0; p_wr_stall = 0;
      end else begin
        sz0 = q.size();
        if (burst_done !== done_exp) viol++;
        if (!wr_en && wr_data !== '0) viol++;
        if (p_cmd_stall && (cmd_en !== 1'b1 || cmd_addr !== p_addr)) viol++;
        if (p_wr_stall && (wr_en !== 1'b1 || wr_data !== p_data)) viol++;
        if (cmd_en2 !== cmd_en || wr_en2 !== wr_en || wr_data2 !== wr_data ||
            fifo_count2 !== fifo_count || ovf2 !== ovf || burst_done2 !== burst_done) viol++;
        if (burst_done) done_cnt++;
        done_exp = 0;
        if (cmd_en && !p_cmd) begin
          real_n = (sz_last < 4) ? sz_last : 4;
          cmd_obs.push_back(cmd_addr);
          cmd2_obs.push_back(cmd_addr2);
          ncmd++;
        end
        if (wr_en && wr_rdy) begin
          if (mbeat < real_n) m_e = (q.size() > 0) ? q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
          else m_e = '0;
          exp_q.push_back(m_e);
          obs_q.push_back(wr_data);
          mbeat++;
          if (mbeat == 4) begin mbeat = 0; nburst++; done_exp = 1; end
        end
        if (din_vd) begin
          if (sz0 < 16) q.push_back(din);
          else m_ovf = 1;
        end
        sz_last = sz0;
        p_cmd = cmd_en; p_addr = cmd_addr; p_data = wr_data;
        p_cmd_stall = cmd_en && !cmd_rdy;
        p_wr_stall = wr_en && !wr_rdy;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [63:0] w);
    din = w; din_vd = 1'b1;
    @(negedge clk);
    din_vd = 1'b0; din = '0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_bursts(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (nburst >= target) ok = 1;
      else @(negedge clk);
    end
    if (nburst >= target) ok = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din_vd = 0; flush = 0; cmd_rdy = 1; wr_rdy = 1;
    repeat (3) @(negedge clk);
    checks++; if (cmd_en !== 1'b0) begin failures++; $display("FAIL reset_cmd_en got %0b expected 0", cmd_en); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got %0b expected 0", wr_en); end
    checks++; if (wr_data !== 64'h0) begin failures++; $display("FAIL reset_wr_data got %0h expected 0", wr_data); end
    checks++; if (cmd_addr !== 24'h0) begin failures++; $display("FAIL reset_cmd_addr got %0h expected 0", cmd_addr); end
    checks++; if (cmd_addr2 !== 4'd12) begin failures++; $display("FAIL reset_cmd_addr2 got %0d expected 12", cmd_addr2); end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL reset_fifo_count got %0d expected 0", fifo_count); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got %0b expected 0", ovf); end
    checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL reset_burst_done got %0b expected 0", burst_done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [63:0] a[8];
    int c0, b0, d0, nb0;
    bit ok;
    logic [23:0] ea;
    logic [3:0] ea2;
    for (int i = 0; i < 8; i++) a[i] = {$urandom, $urandom};
    c0 = ncmd; b0 = obs_q.size(); d0 = done_cnt; nb0 = nburst;
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) push_word(a[4*g+i]);
      wait_bursts(nb0 + g + 1, 60, ok);
      repeat (2) @(negedge clk);
      checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got %0d expected %0d", nburst, nb0 + g + 1); end
      checks++; if (obs_q.size() < b0 + 4*g + 4) begin failures++; $display("FAIL basic_beats got %0d expected %0d", obs_q.size(), b0 + 4*g + 4); end
      else for (int i = 0; i < 4; i++) begin
        checks++; if (obs_q[b0+4*g+i] !== a[4*g+i]) begin failures++; $display("FAIL basic_data got %0h expected %0h", obs_q[b0+4*g+i], a[4*g+i]); end
      end
      ea = 24'(4 * (c0 + g)); ea2 = 4'(12 + 4 * (c0 + g));
      checks++; if (cmd_obs.size() <= c0 + g || cmd_obs[c0+g] !== ea) begin failures++; $display("FAIL basic_addr got %0h expected %0h", (cmd_obs.size() > c0+g) ? cmd_obs[c0+g] : 24'hx, ea); end
      checks++; if (cmd2_obs.size() <= c0 + g || cmd2_obs[c0+g] !== ea2) begin failures++; $display("FAIL wrap_addr got %0d expected %0d", (cmd2_obs.size() > c0+g) ? cmd2_obs[c0+g] : 4'hx, ea2); end
      checks++; if (done_cnt - d0 !== g + 1) begin failures++; $display("FAIL basic_done got %0d expected %0d", done_cnt - d0, g + 1); end
    end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL basic_count got %0d expected 0", fifo_count); end
  endtask

  task automatic test_backpressure();
    logic [63:0] w[4];
    bit pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    int b0, nb0, v0, k;
    bit ok;
    for (int i = 0; i < 4; i++) w[i] = {$urandom, $urandom};
    b0 = obs_q.size(); nb0 = nburst; v0 = viol;
    cmd_rdy = 1; wr_rdy = 0;
    for (int i = 0; i < 4; i++) push_word(w[i]);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (wr_en === 1'b1) ok = 1; else @(negedge clk);
    end
    checks++; if (!ok) begin failures++; $display("FAIL bp_wr_en got 0 expected 1"); end
    checks++; if (fifo_count !== 5'd4) begin failures++; $display("FAIL bp_count_pre got %0d expected 4", fifo_count); end
    k = 0;
    for (int i = 0; i < 7; i++) begin
      checks++; if (wr_data !== w[k]) begin failures++; $display("FAIL bp_hold got %0h expected %0h", wr_data, w[k]); end
      wr_rdy = pat[i];
      @(negedge clk);
      if (pat[i]) k++;
    end
    wr_rdy = 1;
    @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL bp_wr_en_end got %0b expected 0", wr_en); end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL bp_count_post got %0d expected 0", fifo_count); end
    checks++; if (nburst - nb0 !== 1) begin failures++; $display("FAIL bp_bursts got %0d expected 1", nburst - nb0); end
    checks++; if (obs_q.size() !== b0 + 4) begin failures++; $display("FAIL bp_beats got %0d expected %0d", obs_q.size(), b0 + 4); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (obs_q[b0+i] !== w[i]) begin failures++; $display("FAIL bp_order got %0h expected %0h", obs_q[b0+i], w[i]); end
    end
    checks++; if (viol !== v0) begin failures++; $display("FAIL bp_protocol got %0d expected %0d", viol, v0); end
  endtask

  task automatic test_flush();
    logic [63:0] bw[4];
    int c0, b0, nb0;
    bit ok;
    logic [23:0] ea;
    bw[0] = {$urandom, $urandom}; bw[1] = {$urandom, $urandom}; bw[2] = '0; bw[3] = '0;
    c0 = ncmd; b0 = obs_q.size(); nb0 = nburst;
    push_word(bw[0]); push_word(bw[1]);
    repeat (6) @(negedge clk);
    checks++; if (ncmd !== c0) begin failures++; $display("FAIL flush_early_cmd got %0d expected %0d", ncmd, c0); end
    checks++; if (fifo_count !== 5'd2) begin failures++; $display("FAIL flush_count_pre got %0d expected 2", fifo_count); end
    pulse_flush();
    wait_bursts(nb0 + 1, 40, ok);
    @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL flush_timeout got %0d expected %0d", nburst, nb0 + 1); end
    checks++; if (obs_q.size() !== b0 + 4) begin failures++; $display("FAIL flush_beats got %0d expected %0d", obs_q.size(), b0 + 4); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (obs_q[b0+i] !== bw[i]) begin failures++; $display("FAIL flush_data got %0h expected %0h", obs_q[b0+i], bw[i]); end
    end
    ea = 24'(4 * c0);
    checks++; if (cmd_obs.size() <= c0 || cmd_obs[c0] !== ea) begin failures++; $display("FAIL flush_addr got %0h expected %0h", (cmd_obs.size() > c0) ? cmd_obs[c0] : 24'hx, ea); end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL flush_count_post got %0d expected 0", fifo_count); end
    pulse_flush();
    repeat (10) @(negedge clk);
    checks++; if (ncmd !== c0 + 1) begin failures++; $display("FAIL flush_empty_cmd got %0d expected %0d", ncmd, c0 + 1); end
    checks++; if (cmd_en !== 1'b0) begin failures++; $display("FAIL flush_empty_en got %0b expected 0", cmd_en); end
  endtask

  task automatic test_overflow();
    logic [63:0] w[17];
    int c0, b0, nb0;
    bit ok;
    for (int i = 0; i < 17; i++) w[i] = {$urandom, $urandom};
    c0 = ncmd; b0 = obs_q.size(); nb0 = nburst;
    cmd_rdy = 0; wr_rdy = 1;
    for (int i = 0; i < 17; i++) push_word(w[i]);
    checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL ovf_count got %0d expected 16", fifo_count); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got %0b expected 1", ovf); end
    checks++; if (cmd_en !== 1'b1) begin failures++; $display("FAIL ovf_cmd_held got %0b expected 1", cmd_en); end
    cmd_rdy = 1;
    wait_bursts(nb0 + 4, 200, ok);
    repeat (10) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_timeout got %0d expected %0d", nburst, nb0 + 4); end
    checks++; if (ncmd !== c0 + 4) begin failures++; $display("FAIL ovf_cmds got %0d expected %0d", ncmd, c0 + 4); end
    checks++; if (obs_q.size() !== b0 + 16) begin failures++; $display("FAIL ovf_beats got %0d expected %0d", obs_q.size(), b0 + 16); end
    else for (int i = 0; i < 16; i++) begin
      checks++; if (obs_q[b0+i] !== w[i]) begin failures++; $display("FAIL ovf_data got %0h expected %0h", obs_q[b0+i], w[i]); end
    end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %0b expected 1", ovf); end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL ovf_count_post got %0d expected 0", fifo_count); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] w[4];
    bit ok;
    cmd_rdy = 1; wr_rdy = 1;
    for (int i = 0; i < 4; i++) push_word({$urandom, $urandom});
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (wr_en === 1'b1) ok = 1; else @(negedge clk);
    end
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_wr_en got 0 expected 1"); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cmd_en !== 1'b0 || wr_en !== 1'b0) begin failures++; $display("FAIL rstmid_en got %0b%0b expected 00", cmd_en, wr_en); end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL rstmid_count got %0d expected 0", fifo_count); end
    checks++; if (cmd_addr !== 24'h0) begin failures++; $display("FAIL rstmid_addr got %0h expected 0", cmd_addr); end
    checks++; if (cmd_addr2 !== 4'd12) begin failures++; $display("FAIL rstmid_addr2 got %0d expected 12", cmd_addr2); end
    checks++; if (wr_data !== 64'h0 || ovf !== 1'b0) begin failures++; $display("FAIL rstmid_data_ovf got %0h/%0b expected 0/0", wr_data, ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin w[i] = {$urandom, $urandom}; push_word(w[i]); end
    wait_bursts(1, 40, ok);
    @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_timeout got %0d expected 1", nburst); end
    checks++; if (obs_q.size() !== 4) begin failures++; $display("FAIL rstmid_beats got %0d expected 4", obs_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (obs_q[i] !== w[i]) begin failures++; $display("FAIL rstmid_data got %0h expected %0h", obs_q[i], w[i]); end
    end
    checks++; if (cmd_obs.size() < 1 || cmd_obs[0] !== 24'h0) begin failures++; $display("FAIL rstmid_cmd_addr got %0h expected 0", (cmd_obs.size() > 0) ? cmd_obs[0] : 24'hx); end
  endtask

  task automatic test_random();
    int v0, pct;
    bit ok;
    do_reset();
    v0 = viol;
    for (int cyc = 0; cyc < 400; cyc++) begin
      pct = (cyc < 200) ? 80 : 30;
      din_vd  = ($urandom_range(0, 99) < pct);
      din     = {$urandom, $urandom};
      cmd_rdy = ($urandom_range(0, 3) != 0);
      wr_rdy  = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      checks++; if (fifo_count !== 5'(q.size())) begin failures++; $display("FAIL rand_count got %0d expected %0d", fifo_count, q.size()); end
      checks++; if (ovf !== m_ovf) begin failures++; $display("FAIL rand_ovf got %0b expected %0b", ovf, m_ovf); end
    end
    din_vd = 0; din = '0; cmd_rdy = 1; wr_rdy = 1;
    pulse_flush();
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (q.size() == 0 && nburst == ncmd && cmd_en === 1'b0 && wr_en === 1'b0) ok = 1;
      else @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL rand_drain got %0d expected 0", q.size()); end
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_beats got %0d expected %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_data got %0h expected %0h", obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < cmd_obs.size(); i++) begin
      checks++; if (cmd_obs[i] !== 24'(4 * i) || cmd2_obs[i] !== 4'(12 + 4 * i)) begin failures++; $display("FAIL rand_addr got %0h/%0d expected %0h/%0d", cmd_obs[i], cmd2_obs[i], 24'(4 * i), 4'(12 + 4 * i)); end
    end
    checks++; if (done_cnt !== nburst) begin failures++; $display("FAIL rand_done got %0d expected %0d", done_cnt, nburst); end
    checks++; if (viol !== v0) begin failures++; $display("FAIL rand_protocol got %0d expected %0d", viol, v0); end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL rand_count_end got %0d expected 0", fifo_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
